// File: rtl/cod02_pkg.sv
// Shared definitions for the COD02 datapath: state encoding and parameter defaults
// for the Fibonacci fill sequencer.
package cod02_pkg;
  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 5;
  localparam int START_IDX_DEF = 2;
  localparam int LAST_IDX_DEF  = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/fib_seq_ctrl_if.sv
// Three-port register file bus: two registered read ports (r1/r2) and one write port (r3).
interface fib_seq_ctrl_if
  import cod02_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [ADDR_W-1:0] r1_addr;
  logic [ADDR_W-1:0] r2_addr;
  logic [DATA_W-1:0] r1_dout;
  logic [DATA_W-1:0] r2_dout;
  logic [ADDR_W-1:0] r3_addr;
  logic [DATA_W-1:0] r3_din;
  logic              r3_wr;

  modport master (
    output r1_addr, r2_addr, r3_addr, r3_din, r3_wr,
    input  r1_dout, r2_dout
  );

  modport slave (
    input  r1_addr, r2_addr, r3_addr, r3_din, r3_wr,
    output r1_dout, r2_dout
  );
endinterface

// File: rtl/fib_seq_ctrl.sv
// Fills register file entries START_IDX..LAST_IDX with data[n] = data[n-2] + data[n-1],
// two cycles per entry (READ presents addresses, WRITE stores the sum).
module fib_seq_ctrl
  import cod02_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int START_IDX = START_IDX_DEF,
  parameter int LAST_IDX  = LAST_IDX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  fib_seq_ctrl_if.master    rf,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] cur_idx
);

  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_IDX);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_IDX);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W:0]   sum;

  // Extra top bit carries the adder carry-out into the sticky overflow flag.
  assign sum = {1'b0, rf.r1_dout} + {1'b0, rf.r2_dout};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx      <= START_A;
            overflow <= 1'b0;
            state    <= READ;
          end
        end
        READ: state <= WRITE;
        WRITE: begin
          overflow <= overflow | sum[DATA_W];
          if (idx == LAST_A) begin
            state <= DONE;
          end else begin
            idx   <= idx + ADDR_W'(1);
            state <= READ;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read addresses stay on the bus through WRITE; the file holds its outputs while r3_wr is high.
  always_comb begin
    rf.r1_addr = '0;
    rf.r2_addr = '0;
    rf.r3_addr = '0;
    rf.r3_din  = '0;
    rf.r3_wr   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cur_idx    = '0;
    case (state)
      READ: begin
        busy       = 1'b1;
        cur_idx    = idx;
        rf.r1_addr = idx - ADDR_W'(2);
        rf.r2_addr = idx - ADDR_W'(1);
      end
      WRITE: begin
        busy       = 1'b1;
        cur_idx    = idx;
        rf.r1_addr = idx - ADDR_W'(2);
        rf.r2_addr = idx - ADDR_W'(1);
        rf.r3_wr   = 1'b1;
        rf.r3_addr = idx;
        rf.r3_din  = sum[DATA_W-1:0];
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Bench: three sequencer instances (LAST_IDX 31, 3, 2) each beside a behavioural register file,
// checked cycle by cycle against a Fibonacci reference computed from the seeds.
module tb_fib_seq_ctrl;
  import cod02_pkg::*;

  logic clk;
  logic rst;

  logic        start_a [3];
  logic        load_a  [3];
  logic        busy_a  [3];
  logic        done_a  [3];
  logic        ovf_a   [3];
  logic        wr_a    [3];
  logic [4:0]  cidx_a  [3];
  logic [4:0]  waddr_a [3];
  logic [4:0]  r1a_a   [3];
  logic [4:0]  r2a_a   [3];
  logic [31:0] wdin_a  [3];
  logic [31:0] memv    [3][32];
  bit   [31:0] pre     [3][32];

  logic [31:0] expv [32];
  bit          exp_ov;
  int          checks;
  int          failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int L = (g == 0) ? 31 : (g == 1) ? 3 : 2;
    fib_seq_ctrl_if #(.DATA_W(32), .ADDR_W(5)) rf ();
    logic [31:0] mem [32];

    fib_seq_ctrl #(.DATA_W(32), .ADDR_W(5), .START_IDX(2), .LAST_IDX(L)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_a[g]),
      .rf       (rf),
      .busy     (busy_a[g]),
      .done     (done_a[g]),
      .overflow (ovf_a[g]),
      .cur_idx  (cidx_a[g])
    );

    // Register file: registered reads, outputs frozen while a write is presented; no reset.
    always @(posedge clk) begin
      if (load_a[g]) begin
        for (int i = 0; i < 32; i++) mem[i] <= pre[g][i];
      end else if (rf.r3_wr) begin
        mem[rf.r3_addr] <= rf.r3_din;
      end
      if (!rf.r3_wr) begin
        rf.r1_dout <= mem[rf.r1_addr];
        rf.r2_dout <= mem[rf.r2_addr];
      end
    end

    assign memv[g]    = mem;
    assign wr_a[g]    = rf.r3_wr;
    assign waddr_a[g] = rf.r3_addr;
    assign wdin_a[g]  = rf.r3_din;
    assign r1a_a[g]   = rf.r1_addr;
    assign r2a_a[g]   = rf.r2_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain Fibonacci recurrence on the seeded contents, 32-bit wrap, any carry sets overflow.
  task automatic model(input int g, input int first, input int last);
    logic [32:0] s;
    for (int i = 0; i < 32; i++) expv[i] = pre[g][i];
    exp_ov = 1'b0;
    for (int n = first; n <= last; n++) begin
      s = {1'b0, expv[n-2]} + {1'b0, expv[n-1]};
      expv[n] = s[31:0];
      if (s[32]) exp_ov = 1'b1;
    end
  endtask

  task automatic fill(input int g, input logic [31:0] s0, input logic [31:0] s1);
    for (int i = 0; i < 32; i++) pre[g][i] = $urandom;
    pre[g][0] = s0;
    pre[g][1] = s1;
    @(negedge clk) load_a[g] = 1'b1;
    @(negedge clk) load_a[g] = 1'b0;
  endtask

  // One complete run: cycle k counts from the cycle after the accepted start edge.
  task automatic run(input int g, input int first, input int last, input int restart_at);
    int n;
    int ndone;
    int a;
    n = last - first + 1;
    ndone = 0;
    model(g, first, last);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    start_a[g] = 1'b1;
    @(posedge clk);
    #1 start_a[g] = 1'b0;
    for (int k = 1; k <= 2 * n + 3; k++) begin
      @(negedge clk);
      start_a[g] = (k == restart_at);
      if (done_a[g]) ndone++;
      if (k == 1) chk("ovf_cleared", 32'(ovf_a[g]), 32'd0);
      if (k <= 2 * n) begin
        a = first + (k - 1) / 2;
        chk("busy_run", 32'(busy_a[g]), 32'd1);
        chk("cur_idx", 32'(cidx_a[g]), 32'(a));
        chk("r1_addr", 32'(r1a_a[g]), 32'(a - 2));
        chk("r2_addr", 32'(r2a_a[g]), 32'(a - 1));
        chk("r3_wr", 32'(wr_a[g]), 32'(k % 2 == 0));
        if (k % 2 == 0) begin
          chk("wr_addr", 32'(waddr_a[g]), 32'(a));
          chk("wr_din", wdin_a[g], expv[a]);
        end else begin
          chk("rd_din0", wdin_a[g], 32'd0);
        end
      end else if (k == 2 * n + 1) begin
        chk("done_pulse", 32'(done_a[g]), 32'd1);
        chk("busy_done", 32'(busy_a[g]), 32'd0);
        chk("wr_done", 32'(wr_a[g]), 32'd0);
        chk("ovf_done", 32'(ovf_a[g]), 32'(exp_ov));
      end else begin
        chk("idle_busy", 32'(busy_a[g]), 32'd0);
        chk("idle_cidx", 32'(cidx_a[g]), 32'd0);
      end
    end
    start_a[g] = 1'b0;
    chk("done_count", 32'(ndone), 32'd1);
    for (int i = 0; i < 32; i++) chk("contents", memv[g][i], expv[i]);
  endtask

  initial begin
    int cyc;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      start_a[g] = 1'b0;
      load_a[g]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_busy", 32'(busy_a[g]), 32'd0);
      chk("rst_done", 32'(done_a[g]), 32'd0);
      chk("rst_ovf", 32'(ovf_a[g]), 32'd0);
      chk("rst_wr", 32'(wr_a[g]), 32'd0);
      chk("rst_cidx", 32'(cidx_a[g]), 32'd0);
      chk("rst_waddr", 32'(waddr_a[g]), 32'd0);
      chk("rst_din", wdin_a[g], 32'd0);
      chk("rst_r1a", 32'(r1a_a[g]), 32'd0);
    end
    rst = 1'b0;

    // Fibonacci from 1,1 across the full range
    fill(0, 32'd1, 32'd1);
    run(0, 2, 31, 0);
    chk("fib2", memv[0][2], 32'd2);
    chk("fib10", memv[0][10], 32'd89);
    chk("fib31", memv[0][31], 32'd2178309);
    chk("fib_ovf", 32'(ovf_a[0]), 32'd0);

    // Start pulsed mid-run is ignored
    fill(0, 32'd1, 32'd1);
    run(0, 2, 31, 10);

    // Carry sets overflow, which holds after DONE until the next start clears it
    fill(1, 32'h8000_0000, 32'h8000_0000);
    run(1, 2, 3, 0);
    chk("ovf_d2", memv[1][2], 32'h0);
    chk("ovf_d3", memv[1][3], 32'h8000_0000);
    repeat (3) @(negedge clk);
    chk("ovf_hold", 32'(ovf_a[1]), 32'd1);
    fill(1, 32'd1, 32'd1);
    run(1, 2, 3, 0);

    // Single-entry range
    fill(2, 32'd3, 32'd4);
    run(2, 2, 2, 0);
    chk("single_d2", memv[2][2], 32'd7);

    // Random seeds, wrapped values still written
    for (int r = 0; r < 2; r++) begin
      fill(0, $urandom, $urandom);
      run(0, 2, 31, 0);
    end

    // Reset right after the idx=5 write
    fill(0, $urandom_range(1, 1000), $urandom_range(1, 1000));
    model(0, 2, 31);
    start_a[0] = 1'b1;
    @(posedge clk);
    #1 start_a[0] = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(wr_a[0] && waddr_a[0] == 5'd5) && cyc < 40);
    chk("reach_idx5", 32'(cyc), 32'd8);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_busy", 32'(busy_a[0]), 32'd0);
    chk("mrst_wr", 32'(wr_a[0]), 32'd0);
    chk("mrst_cidx", 32'(cidx_a[0]), 32'd0);
    chk("mrst_done", 32'(done_a[0]), 32'd0);
    @(negedge clk);
    chk("mrst_idle", 32'(busy_a[0]), 32'd0);
    for (int i = 0; i < 32; i++)
      chk("mrst_mem", memv[0][i], (i <= 5) ? expv[i] : pre[0][i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
